// File: rtl/run_event_monitor.sv
// rtl/run_event_monitor.sv - classifies detector runs, counts events, tracks run lengths and illegal inputs
module run_event_monitor #(
  parameter int         CNT_W      = 8,
  parameter logic [3:0] ONES_CODE  = 4'b1000,
  parameter logic [3:0] ZEROS_CODE = 4'b0100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             z,
  input  logic [3:0]       state,
  output logic [CNT_W-1:0] ones_events,
  output logic [CNT_W-1:0] zeros_events,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic [1:0]       mode,
  output logic             event_pulse,
  output logic             err
);

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_ones_events;
  logic [CNT_W-1:0] r_zeros_events;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_max_run;
  logic             r_event_pulse;
  logic             r_err;

  logic             w_is_ones;
  logic             w_is_zeros;
  logic [1:0]       w_mode_nxt;
  logic             w_start_ones;
  logic             w_start_zeros;
  logic             w_continue;
  logic             w_illegal;
  logic [CNT_W-1:0] w_ones_nxt;
  logic [CNT_W-1:0] w_zeros_nxt;
  logic [CNT_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_max_nxt;
  logic             w_pulse_nxt;
  logic             w_err_nxt;

  assign w_is_ones  = (state == ONES_CODE);
  assign w_is_zeros = (state == ZEROS_CODE);

  // State register: mode plus all registered outputs; clear acts like reset at an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode         <= MODE_IDLE;
      r_ones_events  <= '0;
      r_zeros_events <= '0;
      r_run_len      <= '0;
      r_max_run      <= '0;
      r_event_pulse  <= 1'b0;
      r_err          <= 1'b0;
    end else if (clear) begin
      r_mode         <= MODE_IDLE;
      r_ones_events  <= '0;
      r_zeros_events <= '0;
      r_run_len      <= '0;
      r_max_run      <= '0;
      r_event_pulse  <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_mode         <= w_mode_nxt;
      r_ones_events  <= w_ones_nxt;
      r_zeros_events <= w_zeros_nxt;
      r_run_len      <= w_run_nxt;
      r_max_run      <= w_max_nxt;
      r_event_pulse  <= w_pulse_nxt;
      r_err          <= w_err_nxt;
    end
  end

  // Next-state: a terminal code with z=1 continues a matching run or starts a new one;
  // z=0 or a non-terminal code with z=1 drops back to IDLE
  always_comb begin
    w_mode_nxt    = MODE_IDLE;
    w_start_ones  = 1'b0;
    w_start_zeros = 1'b0;
    w_continue    = 1'b0;
    w_illegal     = 1'b0;
    if (z) begin
      if (w_is_ones) begin
        w_mode_nxt = MODE_ONES;
        if (r_mode == MODE_ONES) w_continue   = 1'b1;
        else                     w_start_ones = 1'b1;
      end else if (w_is_zeros) begin
        w_mode_nxt = MODE_ZEROS;
        if (r_mode == MODE_ZEROS) w_continue    = 1'b1;
        else                      w_start_zeros = 1'b1;
      end else begin
        w_illegal = 1'b1;
      end
    end
  end

  // Output values for the next edge: saturating counters, run length and running maximum
  always_comb begin
    w_ones_nxt  = r_ones_events;
    w_zeros_nxt = r_zeros_events;
    w_run_nxt   = '0;
    w_pulse_nxt = w_start_ones | w_start_zeros;
    w_err_nxt   = r_err | w_illegal;
    if (w_start_ones && (r_ones_events != CNT_MAX))
      w_ones_nxt = r_ones_events + CNT_ONE;
    if (w_start_zeros && (r_zeros_events != CNT_MAX))
      w_zeros_nxt = r_zeros_events + CNT_ONE;
    if (w_start_ones || w_start_zeros)
      w_run_nxt = CNT_ONE;
    else if (w_continue)
      w_run_nxt = (r_run_len == CNT_MAX) ? CNT_MAX : (r_run_len + CNT_ONE);
    w_max_nxt = (w_run_nxt > r_max_run) ? w_run_nxt : r_max_run;
  end

  assign mode         = r_mode;
  assign ones_events  = r_ones_events;
  assign zeros_events = r_zeros_events;
  assign run_len      = r_run_len;
  assign max_run      = r_max_run;
  assign event_pulse  = r_event_pulse;
  assign err          = r_err;

endmodule

// File: tb/tb_run_event_monitor.sv
// tb/tb_run_event_monitor.sv - randomized self-checking bench for run_event_monitor
module tb_run_event_monitor;

  localparam logic [3:0] ONES  = 4'b1000;
  localparam logic [3:0] ZEROS = 4'b0100;
  localparam int         SAT   = 255;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       z;
  logic [3:0] state;
  logic [7:0] ones_events;
  logic [7:0] zeros_events;
  logic [7:0] run_len;
  logic [7:0] max_run;
  logic [1:0] mode;
  logic       event_pulse;
  logic       err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ones, m_zeros, m_run, m_max, m_mode, m_pulse, m_err;

  run_event_monitor #(.CNT_W(8), .ONES_CODE(ONES), .ZEROS_CODE(ZEROS)) dut (
    .clock(clock), .reset(reset), .clear(clear), .z(z), .state(state),
    .ones_events(ones_events), .zeros_events(zeros_events), .run_len(run_len),
    .max_run(max_run), .mode(mode), .event_pulse(event_pulse), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_clear();
    m_ones = 0; m_zeros = 0; m_run = 0; m_max = 0; m_mode = 0; m_pulse = 0; m_err = 0;
  endfunction

  // one edge of the behaviour: kind 1 = ones run, 2 = zeros run, 0 = no legal run
  function automatic void model_edge(input logic iz, input logic [3:0] ist, input logic iclr);
    int kind;
    if (iclr) begin
      model_clear();
      return;
    end
    kind = (ist == ONES) ? 1 : (ist == ZEROS) ? 2 : 0;
    m_pulse = 0;
    if (!iz) begin
      m_mode = 0; m_run = 0;
    end else if (kind == 0) begin
      m_err = 1; m_mode = 0; m_run = 0;
    end else if (kind == m_mode) begin
      m_run = (m_run + 1 > SAT) ? SAT : m_run + 1;
    end else begin
      m_mode = kind; m_run = 1; m_pulse = 1;
      if (kind == 1) m_ones  = (m_ones + 1 > SAT)  ? SAT : m_ones + 1;
      else           m_zeros = (m_zeros + 1 > SAT) ? SAT : m_zeros + 1;
    end
    if (m_run > m_max) m_max = m_run;
  endfunction

  function automatic logic [35:0] dut_vec();
    return {ones_events, zeros_events, run_len, max_run, mode, event_pulse, err};
  endfunction

  function automatic logic [35:0] model_vec();
    return {m_ones[7:0], m_zeros[7:0], m_run[7:0], m_max[7:0], m_mode[1:0], m_pulse[0], m_err[0]};
  endfunction

  task automatic step(input logic iz, input logic [3:0] ist, input logic iclr);
    z = iz; state = ist; clear = iclr;
    @(posedge clock);
    #1;
    model_edge(iz, ist, iclr);
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; z = 1'b0; state = 4'h0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_initial: got %h required %h", dut_vec(), model_vec());
    end
    reset = 1'b1;
    step(1'b1, ONES, 1'b0);
    step(1'b1, ONES, 1'b0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_prerun: got %h required %h", dut_vec(), model_vec());
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_vec() !== 36'h0) begin
      errors++; $display("FAIL reset_async_noedge: got %h required %h", dut_vec(), 36'h0);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_held: got %h required %h", dut_vec(), model_vec());
    end
    reset = 1'b1;
  endtask

  task automatic test_ones_run();
    int exp_run[4] = '{1, 2, 3, 0};
    int exp_pulse[4] = '{1, 0, 0, 0};
    int exp_mode[4] = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      step(i < 3, ONES, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL ones_run_model step %0d: got %h required %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (run_len !== exp_run[i][7:0] || event_pulse !== exp_pulse[i][0] || mode !== exp_mode[i][1:0]) begin
        errors++;
        $display("FAIL ones_run_seq step %0d: run=%0d pulse=%0d mode=%0d required run=%0d pulse=%0d mode=%0d",
                 i, run_len, event_pulse, mode, exp_run[i], exp_pulse[i], exp_mode[i]);
      end
    end
    checks++;
    if (ones_events !== 8'd1 || max_run !== 8'd3) begin
      errors++; $display("FAIL ones_run_totals: ones=%0d max=%0d required ones=1 max=3", ones_events, max_run);
    end
  endtask

  task automatic test_zeros_after();
    step(1'b1, ZEROS, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || mode !== 2'b10 || zeros_events !== 8'd1) begin
      errors++; $display("FAIL zeros_start: got %h required %h", dut_vec(), model_vec());
    end
    step(1'b0, ZEROS, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || mode !== 2'b00 || ones_events !== 8'd1 || max_run !== 8'd3) begin
      errors++; $display("FAIL zeros_end: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, ONES, 1'b0);
      if (dut_vec() !== model_vec()) bad++;
      step(1'b0, 4'h0, 1'b0);
      if (dut_vec() !== model_vec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sat_runs: %0d mismatching cycles required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      step(1'b1, ONES, 1'b0);
      if (dut_vec() !== model_vec()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL sat_hold: %0d mismatching cycles required 0", bad);
    end
    checks++;
    if (ones_events !== 8'd255 || run_len !== 8'd255 || max_run !== 8'd255) begin
      errors++; $display("FAIL sat_values: ones=%0d run=%0d max=%0d required 255 255 255", ones_events, run_len, max_run);
    end
    step(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_err_clear();
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, ONES, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || err !== 1'b1 || mode !== 2'b00 || ones_events !== 8'd1) begin
      errors++; $display("FAIL err_set: got %h required %h", dut_vec(), model_vec());
    end
    step(1'b0, ONES, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: err=%0d required 1", err);
    end
    step(1'b1, ONES, 1'b1);
    checks++;
    if (dut_vec() !== 36'h0) begin
      errors++; $display("FAIL clear_priority: got %h required %h", dut_vec(), 36'h0);
    end
  endtask

  task automatic test_switch();
    step(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, ONES, 1'b0);
    checks++;
    if (run_len !== 8'd5 || mode !== 2'b01) begin
      errors++; $display("FAIL switch_pre: run=%0d mode=%0d required run=5 mode=1", run_len, mode);
    end
    step(1'b1, ZEROS, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || mode !== 2'b10 || zeros_events !== 8'd1 ||
        run_len !== 8'd1 || event_pulse !== 1'b1 || max_run !== 8'd5) begin
      errors++; $display("FAIL switch_direct: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    logic       rz;
    logic [3:0] rs;
    logic       rc;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: rs = ONES;
        3, 4:    rs = ZEROS;
        default: rs = 4'($urandom_range(0, 15));
      endcase
      rz = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 99) == 0);
      step(rz, rs, rc);
      if (dut_vec() !== model_vec()) begin
        bad++;
        if (bad <= 5) $display("FAIL random step %0d: got %h required %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_total: %0d mismatching cycles required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_ones_run();
    test_zeros_after();
    test_saturation();
    test_err_clear();
    test_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_event_monitor.md
Name: run_event_monitor

Overview:
Downstream consumer of the Part 2 sequence-detector FSM. Samples its z and state outputs every clock and classifies each detection run as a four-ones or four-zeros run. Keeps saturating event counters, the current and longest run lengths, and a sticky error flag for illegal z/state combinations. Outputs feed the board display/LED stage.

Parameters:
CNT_W, 8, width of event counters and run-length registers
ONES_CODE, 4'b1000, state encoding of the detector's "four or more 1s" state (I)
ZEROS_CODE, 4'b0100, state encoding of the detector's "four or more 0s" state (E)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; reset=0 clears all state immediately
clear  input  1  synchronous clear, active-high
z  input  1  detector output
state  input  4  detector state code
ones_events  output  CNT_W  number of ones runs started, saturating
zeros_events  output  CNT_W  number of zeros runs started, saturating
run_len  output  CNT_W  cycles z has been high in the current run, saturating; 0 in IDLE
max_run  output  CNT_W  longest run_len reached since reset/clear
mode  output  2  00 IDLE, 01 ONES, 10 ZEROS (11 never driven)
event_pulse  output  1  high for exactly one cycle after each run start
err  output  1  sticky illegal-input flag

Behaviour:
- All outputs are registered and update on the rising clock edge from the z/state sampled at that edge. Latency is 1 cycle. There is no input synchronisation; z and state come from the same clock domain.
- Reset: when reset=0, all outputs go to 0 asynchronously and mode is IDLE. Reset has priority over everything, including in the middle of a run.
- clear=1 at an edge gives the same result as reset, applied synchronously. It has priority over sampling at that edge, so an event coinciding with clear is not counted.
- A term such as "count++" below always means saturating at 2^CNT_W-1. It never wraps.
- IDLE:
  - z=1, state=ONES_CODE: go to ONES, ones_events++, run_len=1, event_pulse=1.
  - z=1, state=ZEROS_CODE: go to ZEROS, zeros_events++, run_len=1, event_pulse=1.
  - z=1, any other state: err=1, stay in IDLE, counters unchanged.
  - z=0: stay in IDLE.
- ONES:
  - z=1, state=ONES_CODE: run_len++.
  - z=1, state=ZEROS_CODE: go directly to ZEROS, zeros_events++, run_len=1, event_pulse=1.
  - z=1, any other state: err=1, go to IDLE, run_len=0.
  - z=0: go to IDLE, run_len=0.
- ZEROS: symmetric to ONES, with the ONES_CODE and ZEROS_CODE roles swapped.
- event_pulse is 0 on every edge that does not start a run.
- max_run is updated to max(max_run, next run_len) on every edge. A saturated run_len keeps max_run at its maximum value.
- err clears only on reset or clear.
- z=0 with a terminal state code is not an error. It is treated as z=0.

Test Plan:
1. Hold reset=0 for 2 cycles mid-stream, then release -> every output is 0, mode=00, event_pulse=0, and no edge is needed for the clear to take effect.
2. Drive z=1, state=4'b1000 for 3 cycles, then z=0 -> event_pulse high for 1 cycle only, ones_events=1, run_len 1,2,3 then 0, mode 01 then 00, max_run=3.
3. Continue from 2 with z=1, state=4'b0100 for 1 cycle, then z=0 -> zeros_events=1, ones_events=1, max_run stays 3, mode 10 then 00.
4. Drive 300 separate ones runs, then hold one run for 260 cycles -> ones_events=255, run_len=255, max_run=255, no wrap.
5. Drive z=1, state=4'b0010 -> err=1, mode=00, counters unchanged. Then drive clear=1 on the same edge as a legal ones start -> all outputs 0 and ones_events stays 0.
6. From ONES with run_len=5, drive z=1, state=4'b0100 -> mode=10, zeros_events+1, run_len=1, event_pulse=1, max_run=5.
